// File: rtl/io_bus_fabric.sv
// Data-side bus fabric: routes processor data accesses to the unified SRAM
// port or to one of NUM_SLAVES memory-mapped IO slaves. IO accesses use a
// ready handshake with a processor stall, a timeout and bus-error reporting.
module io_bus_fabric #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_SLAVES = 4,
  parameter logic [15:0]           IO_TAG     = 16'hFFFF,
  parameter int                    SLOT_LSB   = 8,
  parameter int                    TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             proc_req,
  input  logic [ADDR_WIDTH-1:0]            proc_addr,
  input  logic [DATA_WIDTH-1:0]            proc_wdata,
  input  logic [DATA_WIDTH/8-1:0]          proc_bwe,
  output logic [DATA_WIDTH-1:0]            proc_rdata,
  output logic                             proc_stall,
  output logic [DATA_WIDTH/8-1:0]          mem_bwe,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [NUM_SLAVES-1:0]            io_sel,
  output logic [ADDR_WIDTH-1:0]            io_addr,
  output logic [DATA_WIDTH-1:0]            io_wdata,
  output logic [DATA_WIDTH/8-1:0]          io_bwe,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] io_rdata,
  input  logic [NUM_SLAVES-1:0]            io_ready,
  output logic                             bus_err,
  output logic [7:0]                       err_count,
  output logic [ADDR_WIDTH-1:0]            err_addr
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IO_ACCESS = 2'd1,
    IO_DONE   = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [3:0]              slot, slot_q;
  logic                    is_io, mapped;
  logic [7:0]              wait_cnt;
  logic                    timed_out;
  logic [DATA_WIDTH-1:0]   rdata_q, sel_rdata;
  logic                    sel_ready;
  logic [NUM_SLAVES-1:0]   slot_onehot;
  logic                    err_event;
  logic [ADDR_WIDTH-1:0]   err_src_addr;

  assign slot      = proc_addr[SLOT_LSB+3:SLOT_LSB];
  assign is_io     = proc_req && (proc_addr[ADDR_WIDTH-1 -: 16] == IO_TAG);
  assign mapped    = ({1'b0, slot} < 5'(NUM_SLAVES));
  assign timed_out = (wait_cnt == 8'(TIMEOUT));

  // Slave read-data/ready mux on the latched slot, plus one-hot decode of the live slot.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    sel_rdata   = '0;
    sel_ready   = 1'b0;
    slot_onehot = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (slot_q == 4'(k)) begin
        sel_rdata = io_rdata[k*DATA_WIDTH +: DATA_WIDTH];
        sel_ready = io_ready[k];
      end
      if (slot == 4'(k)) slot_onehot[k] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a ready in the timeout cycle still completes normally.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (is_io) state_next = mapped ? IO_ACCESS : IO_DONE;
      IO_ACCESS: if (sel_ready || timed_out) state_next = IO_DONE;
      IO_DONE:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Processor-facing outputs; memory never stalls and never sees IO writes.
  always_comb begin
    proc_stall = ((state == IDLE) && is_io) || (state == IO_ACCESS);
    mem_bwe    = ((state == IDLE) && proc_req && !is_io) ? proc_bwe : '0;
    proc_rdata = (state == IDLE) ? mem_rdata : rdata_q;
  end

  // Error source: unmapped slot at decode, or an IO access that ran out of time.
  always_comb begin
    err_event    = ((state == IDLE) && is_io && !mapped) ||
                   ((state == IO_ACCESS) && !sel_ready && timed_out);
    err_src_addr = (state == IDLE) ? proc_addr : io_addr;
  end

  // IO channel registers, read-data capture and error bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_sel    <= '0;
      io_addr   <= '0;
      io_wdata  <= '0;
      io_bwe    <= '0;
      slot_q    <= '0;
      wait_cnt  <= '0;
      rdata_q   <= '0;
      bus_err   <= 1'b0;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      bus_err <= err_event;
      if (err_event) begin
        rdata_q  <= ERR_DATA;
        err_addr <= err_src_addr;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
      case (state)
        IDLE: begin
          if (is_io && mapped) begin
            io_sel   <= slot_onehot;
            io_addr  <= proc_addr;
            io_wdata <= proc_wdata;
            io_bwe   <= proc_bwe;
            slot_q   <= slot;
            wait_cnt <= '0;
          end
        end
        IO_ACCESS: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (sel_ready) rdata_q <= sel_rdata;
          if (sel_ready || timed_out) begin
            io_sel <= '0;
            io_bwe <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_fabric.sv
// Directed self-checking bench for io_bus_fabric (TIMEOUT overridden to 8).
module tb_io_bus_fabric;

  logic         clk = 1'b0;
  logic         rst;
  logic         proc_req;
  logic [31:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [3:0]   proc_bwe;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic [3:0]   mem_bwe;
  logic [31:0]  mem_rdata;
  logic [3:0]   io_sel;
  logic [31:0]  io_addr;
  logic [31:0]  io_wdata;
  logic [3:0]   io_bwe;
  logic [127:0] io_rdata;
  logic [3:0]   io_ready;
  logic         bus_err;
  logic [7:0]   err_count;
  logic [31:0]  err_addr;

  int checks = 0;
  int errors = 0;

  io_bus_fabric #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .proc_req(proc_req), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_bwe(proc_bwe), .proc_rdata(proc_rdata), .proc_stall(proc_stall),
    .mem_bwe(mem_bwe), .mem_rdata(mem_rdata),
    .io_sel(io_sel), .io_addr(io_addr), .io_wdata(io_wdata), .io_bwe(io_bwe),
    .io_rdata(io_rdata), .io_ready(io_ready),
    .bus_err(bus_err), .err_count(err_count), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold one access until the stall drops. The addressed slave raises ready
  // on cycle rdy_cycle (cycle 0 is the decode cycle); every other slave holds
  // ready high throughout so that ignoring non-selected slaves is exercised.
  task automatic io_txn(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] bwe, input int slot, input int rdy_cycle,
                        output int n_stall, output int n_sel, output int n_err,
                        output logic [31:0] rdata, output logic clean,
                        output logic finished);
    logic [3:0] own;
    own      = 4'(1 << slot);
    n_stall  = 0;
    n_sel    = 0;
    n_err    = 0;
    rdata    = '0;
    clean    = 1'b1;
    finished = 1'b0;
    for (int c = 0; c < 400 && !finished; c++) begin
      @(posedge clk); #1;
      proc_req   = 1'b1;
      proc_addr  = addr;
      proc_wdata = wdata;
      proc_bwe   = bwe;
      io_ready   = (c == rdy_cycle) ? own : ~own;
      #1;
      if (proc_stall) n_stall++;
      else begin
        rdata    = proc_rdata;
        finished = 1'b1;
      end
      if (io_sel != 4'b0) begin
        n_sel++;
        if (io_sel !== own || io_wdata !== wdata || io_bwe !== bwe || io_addr !== addr)
          clean = 1'b0;
      end
      if (mem_bwe !== 4'b0) clean = 1'b0;
      if (bus_err) n_err++;
    end
    @(posedge clk); #1;
    proc_req = 1'b0;
    proc_bwe = 4'b0;
    io_ready = 4'b0;
  endtask

  int          n_stall, n_sel, n_err;
  logic [31:0] rdata;
  logic        clean, finished;

  initial begin
    rst        = 1'b1;
    proc_req   = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    proc_bwe   = '0;
    mem_rdata  = 32'h0BAD_F00D;
    io_ready   = '0;
    for (int k = 0; k < 4; k++) io_rdata[k*32 +: 32] = 32'hA0A0_0000 + 32'(k);
    io_rdata[2*32 +: 32] = 32'h1234_5678;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_stall", 32'(proc_stall), 32'd0);
    check("rst_io_sel", 32'(io_sel), 32'd0);
    check("rst_io_addr", io_addr, 32'd0);
    check("rst_io_wdata", io_wdata, 32'd0);
    check("rst_io_bwe", 32'(io_bwe), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    check("rst_rdata", proc_rdata, 32'h0BAD_F00D);

    // Idle with write enables but no request: memory must not be written
    proc_bwe = 4'b1111;
    #1;
    check("noreq_mem_bwe", 32'(mem_bwe), 32'd0);

    // Memory write passes straight through
    @(posedge clk); #1;
    proc_req = 1'b1; proc_addr = 32'h0000_0040; proc_bwe = 4'b0011; proc_wdata = 32'h5555_AAAA;
    #1;
    check("memw_mem_bwe", 32'(mem_bwe), 32'h3);
    check("memw_stall", 32'(proc_stall), 32'd0);
    check("memw_io_sel", 32'(io_sel), 32'd0);
    @(posedge clk); #1;
    check("memw_io_sel_next", 32'(io_sel), 32'd0);

    // Memory read returns SRAM data without stall
    proc_addr = 32'h0000_0080; proc_bwe = 4'b0000; mem_rdata = 32'hC0DE_0080;
    #1;
    check("memr_rdata", proc_rdata, 32'hC0DE_0080);
    check("memr_stall", 32'(proc_stall), 32'd0);
    proc_req = 1'b0;

    // IO read slot 2, immediate ready
    io_txn(32'hFFFF_0200, 32'h0, 4'b0000, 2, 1, n_stall, n_sel, n_err, rdata, clean, finished);
    check("rd2_done", 32'(finished), 32'd1);
    check("rd2_stall", 32'(n_stall), 32'd2);
    check("rd2_sel", 32'(n_sel), 32'd1);
    check("rd2_rdata", rdata, 32'h1234_5678);
    check("rd2_err", 32'(n_err), 32'd0);
    check("rd2_clean", 32'(clean), 32'd1);

    // IO write slot 1, ready delayed 5 cycles
    io_txn(32'hFFFF_0104, 32'hCAFE_F00D, 4'b1111, 1, 6, n_stall, n_sel, n_err, rdata, clean, finished);
    check("wr1_done", 32'(finished), 32'd1);
    check("wr1_stall", 32'(n_stall), 32'd7);
    check("wr1_sel", 32'(n_sel), 32'd6);
    check("wr1_err", 32'(n_err), 32'd0);
    check("wr1_clean", 32'(clean), 32'd1);
    check("wr1_io_bwe_after", 32'(io_bwe), 32'd0);

    // Memory access right after an IO access is not blocked
    proc_req = 1'b1; proc_addr = 32'h0000_0100; proc_bwe = 4'b1100;
    #1;
    check("post_io_mem_bwe", 32'(mem_bwe), 32'hC);
    @(posedge clk); #1;
    proc_req = 1'b0; proc_bwe = 4'b0;

    // Timeout on slot 0: 9 access cycles (counter 0..8)
    io_txn(32'hFFFF_0000, 32'h0, 4'b0000, 0, -1, n_stall, n_sel, n_err, rdata, clean, finished);
    check("to_done", 32'(finished), 32'd1);
    check("to_stall", 32'(n_stall), 32'd10);
    check("to_sel", 32'(n_sel), 32'd9);
    check("to_err_pulse", 32'(n_err), 32'd1);
    check("to_rdata", rdata, 32'hDEAD_BEEF);
    check("to_err_addr", err_addr, 32'hFFFF_0000);
    check("to_err_count", 32'(err_count), 32'd1);

    // Ready arriving in the timeout cycle wins
    io_txn(32'hFFFF_0300, 32'h0, 4'b0000, 3, 9, n_stall, n_sel, n_err, rdata, clean, finished);
    check("tie_stall", 32'(n_stall), 32'd10);
    check("tie_err", 32'(n_err), 32'd0);
    check("tie_rdata", rdata, 32'hA0A0_0003);
    check("tie_err_count", 32'(err_count), 32'd1);

    // Unmapped slot 5
    io_txn(32'hFFFF_0500, 32'h0, 4'b0000, 5, -1, n_stall, n_sel, n_err, rdata, clean, finished);
    check("um_done", 32'(finished), 32'd1);
    check("um_stall", 32'(n_stall), 32'd1);
    check("um_sel", 32'(n_sel), 32'd0);
    check("um_err_pulse", 32'(n_err), 32'd1);
    check("um_rdata", rdata, 32'hDEAD_BEEF);
    check("um_err_addr", err_addr, 32'hFFFF_0500);
    check("um_err_count", 32'(err_count), 32'd2);

    // 299 more unmapped accesses: counter saturates
    for (int i = 0; i < 299; i++)
      io_txn(32'hFFFF_0500, 32'h0, 4'b0000, 5, -1, n_stall, n_sel, n_err, rdata, clean, finished);
    check("sat_err_count", 32'(err_count), 32'd255);
    check("sat_last_err", 32'(n_err), 32'd1);

    // Reset in the middle of an IO access
    @(posedge clk); #1;
    proc_req = 1'b1; proc_addr = 32'hFFFF_0100; proc_bwe = 4'b0; io_ready = 4'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_io_sel", 32'(io_sel), 32'h2);
    check("mid_stall", 32'(proc_stall), 32'd1);
    rst = 1'b1; proc_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst2_io_sel", 32'(io_sel), 32'd0);
    check("rst2_stall", 32'(proc_stall), 32'd0);
    check("rst2_err_count", 32'(err_count), 32'd0);
    check("rst2_err_addr", err_addr, 32'd0);
    check("rst2_bus_err", 32'(bus_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
